// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR command arbiter.
// State encoding, grant polarity and streak counter width.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic GNT_RD = 1'b0;
    localparam logic GNT_WR = 1'b1;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/ddr_arb_wdog.sv
// Watchdog for the DDR command arbiter: counts busy cycles and
// flags a timeout on the WDOG_CYCLES-th one (DDR_ARB_WDOG_EN builds).
module ddr_arb_wdog #(
    parameter logic [15:0] WDOG_CYCLES = 16'hFFFF
) (
    input  logic ddr_clk,
    input  logic ddr_rst,
    input  logic run,
    output logic timeout
);

    logic [15:0] cnt;

    // Count cycles spent in ISSUE/WAIT; cleared whenever the FSM is idle
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign timeout = run && (cnt == WDOG_CYCLES - 16'd1);

endmodule

// File: rtl/ddr_cmd_arb.sv
// Single-port DDR command arbiter, read-biased weighted priority.
// Optional watchdog compiled in with `define DDR_ARB_WDOG_EN.
module ddr_cmd_arb
    import ddr_arb_pkg::*;
#(
    parameter int          CTRL_ADDR_WIDTH = 28,
    parameter int          LEN_WIDTH       = 32,
    parameter int          RD_WEIGHT       = 4,
    parameter logic [15:0] WDOG_CYCLES     = 16'hFFFF
) (
    input  logic                       ddr_clk,
    input  logic                       ddr_rst,
    input  logic                       wr_req,
    input  logic [CTRL_ADDR_WIDTH-1:0] wr_addr,
    input  logic [LEN_WIDTH-1:0]       wr_len,
    output logic                       wr_rdy,
    output logic                       wr_done,
    input  logic                       rd_req,
    input  logic [CTRL_ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]       rd_len,
    output logic                       rd_rdy,
    output logic                       rd_done,
    output logic                       cmd_en,
    output logic                       cmd_wr,
    output logic [CTRL_ADDR_WIDTH-1:0] cmd_addr,
    output logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       cmd_ready,
    input  logic                       cmd_done,
    output logic                       arb_busy,
    output logic                       wdog_err
);

    localparam logic [STREAK_W-1:0] RD_W = STREAK_W'(RD_WEIGHT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

    state_t              state;
    state_t              state_nx;
    logic [STREAK_W-1:0] rd_streak;
    logic                gnt_wr;
    logic                grant;
    logic                accept;
    logic                fin;
    logic                tmo;

    assign cmd_en   = (state == ISSUE);
    assign arb_busy = (state != IDLE);

    // State register
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant decision and next state; a watchdog timeout overrides all
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        accept   = 1'b0;
        fin      = 1'b0;
        gnt_wr   = wr_req & (~rd_req | (rd_streak >= RD_W));
        unique case (state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    grant    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cmd_done) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (tmo) begin
            fin      = 1'b1;
            state_nx = IDLE;
        end
    end

    // Latch the winning command, track the read streak, emit pulses
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            cmd_wr    <= GNT_RD;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            rd_streak <= '0;
            wr_rdy    <= 1'b0;
            rd_rdy    <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            if (grant) begin
                cmd_wr   <= gnt_wr ? GNT_WR : GNT_RD;
                cmd_addr <= gnt_wr ? wr_addr : rd_addr;
                cmd_len  <= gnt_wr ? wr_len : rd_len;
                if (gnt_wr) begin
                    rd_streak <= '0;
                end else if (rd_streak != STREAK_MAX) begin
                    rd_streak <= rd_streak + 1'b1;
                end
            end
            wr_rdy  <= accept & (cmd_wr == GNT_WR);
            rd_rdy  <= accept & (cmd_wr == GNT_RD);
            wr_done <= fin & (cmd_wr == GNT_WR);
            rd_done <= fin & (cmd_wr == GNT_RD);
        end
    end

`ifdef DDR_ARB_WDOG_EN
    logic wdog_err_q;

    ddr_arb_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .ddr_clk(ddr_clk),
        .ddr_rst(ddr_rst),
        .run    (arb_busy),
        .timeout(tmo)
    );

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            wdog_err_q <= 1'b0;
        end else if (tmo) begin
            wdog_err_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic wdog_unused;

    assign tmo         = 1'b0;
    assign wdog_err    = 1'b0;
    assign wdog_unused = |WDOG_CYCLES;
`endif

endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Self-checking bench for ddr_cmd_arb: scoreboard of expected grants,
// controller model driving cmd_ready/cmd_done with chosen delays.
module tb_ddr_cmd_arb;

    localparam int AW = 28;
    localparam int LW = 32;
    localparam int RW = 4;
    localparam int WD = 100;

    logic          ddr_clk = 1'b0;
    logic          ddr_rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [LW-1:0] wr_len = '0;
    logic          wr_rdy;
    logic          wr_done;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [LW-1:0] rd_len = '0;
    logic          rd_rdy;
    logic          rd_done;
    logic          cmd_en;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready = 1'b0;
    logic          cmd_done = 1'b0;
    logic          arb_busy;
    logic          wdog_err;

    ddr_cmd_arb #(
        .CTRL_ADDR_WIDTH(AW),
        .LEN_WIDTH      (LW),
        .RD_WEIGHT      (RW),
        .WDOG_CYCLES    (16'(WD))
    ) dut (
        .ddr_clk  (ddr_clk),
        .ddr_rst  (ddr_rst),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_len   (wr_len),
        .wr_rdy   (wr_rdy),
        .wr_done  (wr_done),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_len   (rd_len),
        .rd_rdy   (rd_rdy),
        .rd_done  (rd_done),
        .cmd_en   (cmd_en),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_ready(cmd_ready),
        .cmd_done (cmd_done),
        .arb_busy (arb_busy),
        .wdog_err (wdog_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   m_streak = 0;
    int   last_en = 0;
    int   last_done = 0;
    int   n_wr_rdy = 0;
    int   n_wr_done = 0;
    int   n_rd_rdy = 0;
    int   n_rd_done = 0;

    always @(posedge ddr_clk) cyc <= cyc + 1;

    always @(negedge ddr_clk) begin
        if (wr_rdy === 1'b1) n_wr_rdy++;
        if (wr_done === 1'b1) n_wr_done++;
        if (rd_rdy === 1'b1) n_rd_rdy++;
        if (rd_done === 1'b1) n_rd_done++;
    end

    task automatic step();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic push_grant(input bit wr);
        exp_t e;
        e.wr   = wr;
        e.addr = wr ? wr_addr : rd_addr;
        e.len  = wr ? wr_len : rd_len;
        sb.push_back(e);
        if (wr) m_streak = 0;
        else if (m_streak < 15) m_streak++;
    endtask

    task automatic push_both();
        push_grant(m_streak >= RW);
    endtask

    // Controller model: waits for cmd_en, accepts after rdly cycles,
    // completes ddly cycles after the accept cycle.
    task automatic serve(input int rdly, input int ddly,
                         input bit tie, input bit drop);
        exp_t e;
        int   n;
        n = 0;
        while (cmd_en !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cmd_en !== 1'b1) begin
            errors++;
            $display("FAIL serve_wait cmd_en=%b required 1", cmd_en);
            return;
        end
        last_en = cyc;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty unexpected grant wr=%b", cmd_wr);
            return;
        end
        e = sb.pop_front();
        if (cmd_wr !== e.wr || cmd_addr !== e.addr || cmd_len !== e.len) begin
            errors++;
            $display("FAIL grant got wr=%b addr=%h len=%0d required wr=%b addr=%h len=%0d",
                     cmd_wr, cmd_addr, cmd_len, e.wr, e.addr, e.len);
        end
        repeat (rdly) step();
        cmd_ready = 1'b1;
        step();
        if (!tie) cmd_ready = 1'b0;
        checks++;
        if (wr_rdy !== e.wr || rd_rdy !== !e.wr || cmd_en !== 1'b0) begin
            errors++;
            $display("FAIL rdy got wr_rdy=%b rd_rdy=%b cmd_en=%b required %b %b 0",
                     wr_rdy, rd_rdy, cmd_en, e.wr, !e.wr);
        end
        if (drop) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        repeat (ddly - 1) step();
        cmd_done  = 1'b1;
        last_done = cyc;
        step();
        cmd_done = 1'b0;
        checks++;
        if (wr_done !== e.wr || rd_done !== !e.wr || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL done got wr_done=%b rd_done=%b busy=%b required %b %b 0",
                     wr_done, rd_done, arb_busy, e.wr, !e.wr);
        end
    endtask

    task automatic test_reset();
        ddr_rst = 1'b1;
        repeat (3) step();
        checks++;
        if (cmd_en !== 1'b0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_en got en=%b busy=%b required 0 0", cmd_en, arb_busy);
        end
        checks++;
        if (cmd_wr !== 1'b0 || cmd_addr !== '0 || cmd_len !== '0) begin
            errors++;
            $display("FAIL reset_cmd got wr=%b addr=%h len=%h required 0",
                     cmd_wr, cmd_addr, cmd_len);
        end
        checks++;
        if ({wr_rdy, wr_done, rd_rdy, rd_done, wdog_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b required 00000",
                     {wr_rdy, wr_done, rd_rdy, rd_done, wdog_err});
        end
        ddr_rst  = 1'b0;
        m_streak = 0;
        step();
    endtask

    task automatic test_write_only();
        int t_req, wr0, wd0, r0;
        wr0     = n_wr_rdy;
        wd0     = n_wr_done;
        r0      = n_rd_rdy + n_rd_done;
        wr_addr = 28'h0000400;
        wr_len  = 32'd40;
        wr_req  = 1'b1;
        push_grant(1'b1);
        t_req = cyc;
        serve(2, 50, 1'b0, 1'b1);
        checks++;
        if (last_en !== t_req + 1) begin
            errors++;
            $display("FAIL wr_latency got cmd_en at %0d required %0d", last_en, t_req + 1);
        end
        step();
        checks++;
        if (n_wr_rdy - wr0 !== 1 || n_wr_done - wd0 !== 1) begin
            errors++;
            $display("FAIL wr_pulses got rdy=%0d done=%0d required 1 1",
                     n_wr_rdy - wr0, n_wr_done - wd0);
        end
        checks++;
        if (n_rd_rdy + n_rd_done - r0 !== 0) begin
            errors++;
            $display("FAIL rd_silent got %0d rd pulses required 0",
                     n_rd_rdy + n_rd_done - r0);
        end
    endtask

    task automatic test_weighted_arb();
        wr_addr = 28'h0001000;
        wr_len  = 32'd16;
        rd_addr = 28'h0AB0000;
        rd_len  = 32'd64;
        for (int i = 0; i < 10; i++) push_both();
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) serve(1, 3, 1'b0, i == 9);
        repeat (3) step();
        checks++;
        if (arb_busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL arb_drain got busy=%b left=%0d required 0 0",
                     arb_busy, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int pe, pd;
        rd_addr = 28'h0200000;
        rd_len  = 32'd128;
        for (int i = 0; i < 3; i++) push_grant(1'b0);
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe = last_en;
            pd = last_done;
            serve(0, 2, 1'b1, i == 2);
            if (i > 0) begin
                checks++;
                if (last_en !== pd + 2 || last_en - pe !== 4) begin
                    errors++;
                    $display("FAIL b2b_spacing got en=%0d gap=%0d required %0d 4",
                             last_en, last_en - pe, pd + 2);
                end
            end
        end
        cmd_ready = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        int   n, d0;
        rd_addr = 28'h0123456;
        rd_len  = 32'd8;
        push_grant(1'b0);
        rd_req = 1'b1;
        n = 0;
        while (cmd_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (cmd_en !== 1'b1 || cmd_addr !== e.addr || cmd_wr !== e.wr) begin
            errors++;
            $display("FAIL rst_grant got en=%b addr=%h required 1 %h",
                     cmd_en, cmd_addr, e.addr);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        rd_req    = 1'b0;
        step();
        checks++;
        if (arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_wait got busy=%b required 1", arb_busy);
        end
        ddr_rst = 1'b1;
        step();
        checks++;
        if ({cmd_en, cmd_wr, arb_busy, wr_rdy, wr_done, rd_rdy, rd_done} !== 7'b0 ||
            cmd_addr !== '0 || cmd_len !== '0) begin
            errors++;
            $display("FAIL rst_outputs got flags=%b addr=%h len=%h required 0",
                     {cmd_en, cmd_wr, arb_busy, wr_rdy, wr_done, rd_rdy, rd_done},
                     cmd_addr, cmd_len);
        end
        ddr_rst  = 1'b0;
        m_streak = 0;
        step();
        d0       = n_rd_done + n_wr_done;
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        repeat (2) step();
        checks++;
        if (n_rd_done + n_wr_done - d0 !== 0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_stray_done got %0d done pulses busy=%b required 0 0",
                     n_rd_done + n_wr_done - d0, arb_busy);
        end
    endtask

    task automatic test_done_in_idle();
        int d0, t_req;
        d0       = n_rd_done + n_wr_done;
        cmd_done = 1'b1;
        step();
        checks++;
        if (arb_busy !== 1'b0 || cmd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_state got busy=%b en=%b required 0 0",
                     arb_busy, cmd_en);
        end
        cmd_done = 1'b0;
        repeat (2) step();
        checks++;
        if (n_rd_done + n_wr_done - d0 !== 0) begin
            errors++;
            $display("FAIL idle_done_pulse got %0d required 0",
                     n_rd_done + n_wr_done - d0);
        end
        wr_addr = 28'hFFFFFFF;
        wr_len  = 32'hFFFFFFFF;
        wr_req  = 1'b1;
        push_grant(1'b1);
        t_req = cyc;
        serve(0, 1, 1'b0, 1'b1);
        checks++;
        if (last_en !== t_req + 1) begin
            errors++;
            $display("FAIL idle_resume got cmd_en at %0d required %0d",
                     last_en, t_req + 1);
        end
        repeat (2) step();
    endtask

    task automatic test_wdog();
`ifdef DDR_ARB_WDOG_EN
        exp_t e;
        int   n, e_cyc;
        rd_addr = 28'h0777000;
        rd_len  = 32'd32;
        push_grant(1'b0);
        rd_req = 1'b1;
        n = 0;
        while (cmd_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        e_cyc = cyc;
        e     = sb.pop_front();
        checks++;
        if (cmd_en !== 1'b1 || cmd_addr !== e.addr) begin
            errors++;
            $display("FAIL wdog_grant got en=%b addr=%h required 1 %h",
                     cmd_en, cmd_addr, e.addr);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        rd_req    = 1'b0;
        n = 0;
        while (rd_done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (rd_done !== 1'b1 || cyc !== e_cyc + WD) begin
            errors++;
            $display("FAIL wdog_done got rd_done=%b at %0d required 1 at %0d",
                     rd_done, cyc, e_cyc + WD);
        end
        checks++;
        if (wdog_err !== 1'b1 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL wdog_err got err=%b busy=%b required 1 0", wdog_err, arb_busy);
        end
        wr_addr = 28'h0000800;
        wr_len  = 32'd4;
        wr_req  = 1'b1;
        push_grant(1'b1);
        serve(1, 2, 1'b0, 1'b1);
        checks++;
        if (wdog_err !== 1'b1) begin
            errors++;
            $display("FAIL wdog_sticky got %b required 1", wdog_err);
        end
        ddr_rst = 1'b1;
        step();
        ddr_rst  = 1'b0;
        m_streak = 0;
        checks++;
        if (wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear got %b required 0", wdog_err);
        end
        step();
`else
        checks++;
        if (wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_tied got %b required 0", wdog_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_weighted_arb();
        test_back_to_back();
        test_reset_in_wait();
        test_done_in_idle();
        test_wdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

endmodule
